// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared memory port: data has priority, but only
// for a bounded streak while fetch waits. Optional watchdog: MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned DATA_STREAK_MAX = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_valid,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        grant,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D} state_t;

  localparam int unsigned SW = $clog2(DATA_STREAK_MAX + 1) > 0 ? $clog2(DATA_STREAK_MAX + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);

  state_t        state;
  logic [SW-1:0] streak;
  logic          take_data;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1) > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tcount;
`else
  assign timeout = 1'b0;
`endif

  // Fetch wins a contested IDLE cycle only once data has used up its streak.
  assign take_data = d_req && (!f_req || (streak < STREAK_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      streak    <= '0;
      f_valid   <= 1'b0;
      f_rdata   <= '0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      mem_ready <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      busy      <= 1'b0;
      grant     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      tcount    <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      f_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (take_data) begin
            state     <= BUSY_D;
            mem_ready <= 1'b1;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wstrb <= d_wstrb;
            busy      <= 1'b1;
            grant     <= 1'b1;
            if (!f_req)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            tcount    <= '0;
`endif
          end else if (f_req) begin
            state     <= BUSY_F;
            mem_ready <= 1'b1;
            mem_addr  <= f_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            busy      <= 1'b1;
            grant     <= 1'b0;
            streak    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            tcount    <= '0;
`endif
          end
        end
        BUSY_F, BUSY_D: begin
          if (mem_valid) begin
            if (state == BUSY_D) begin
              d_rdata <= mem_rdata;
              d_valid <= 1'b1;
            end else begin
              f_rdata <= mem_rdata;
              f_valid <= 1'b1;
            end
            mem_ready <= 1'b0;
            mem_wstrb <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
          end else if (tcount == T_LAST) begin
            // Abort: owner still gets its single pulse, with zero data.
            if (state == BUSY_D) begin
              d_rdata <= '0;
              d_valid <= 1'b1;
            end else begin
              f_rdata <= '0;
              f_valid <= 1'b1;
            end
            mem_ready <= 1'b0;
            mem_wstrb <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b1;
            state     <= IDLE;
          end else begin
            tcount <= tcount + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written
// sequences for contention, reset mid-transaction and the optional watchdog.
module tb_mem_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 256;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req, mem_valid;
  logic [31:0] f_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wstrb;
  logic        f_valid, d_valid, mem_ready, busy, grant, timeout;
  logic [31:0] f_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int unsigned errors = 0;
  int unsigned checks = 0;

  mem_arbiter #(.DATA_STREAK_MAX(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_valid(f_valid), .f_rdata(f_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .busy(busy), .grant(grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fq;  logic [31:0] fa;
    logic        dq;  logic [31:0] da; logic [31:0] dw; logic [3:0] ds;
    logic        mv;  logic [31:0] mr;
    logic        fv;  logic [31:0] frd;
    logic        dv;  logic [31:0] drd;
    logic        mrdy; logic [31:0] maddr; logic [3:0] mws; logic [31:0] mwd;
    logic        bsy; logic        gnt;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 0; f_addr = '0; d_req = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_valid = 0; mem_rdata = '0;
  endtask

  initial begin
    //          fq fa        dq da         dw            ds    mv mr            | fv frd    dv drd           mrdy maddr      mws   mwd           bsy gnt
    vecs[0]  = '{1, 32'h100, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,         0, 32'h0,  0, 32'h0,        1, 32'h100,  4'h0, 32'h0,        1, 0};
    vecs[1]  = '{1, 32'h100, 1, 32'h999,  32'h1234,     4'hF, 0, 32'h0,         0, 32'h0,  0, 32'h0,        1, 32'h100,  4'h0, 32'h0,        1, 0};
    vecs[2]  = '{1, 32'h100, 0, 32'h0,    32'h0,        4'h0, 1, 32'h13,        1, 32'h13, 0, 32'h0,        0, 32'h0,    4'h0, 32'h0,        0, 0};
    vecs[3]  = '{0, 32'h0,   0, 32'h0,    32'h0,        4'h0, 0, 32'h0,         0, 32'h13, 0, 32'h0,        0, 32'h0,    4'h0, 32'h0,        0, 0};
    vecs[4]  = '{0, 32'h0,   1, 32'h2004, 32'hCAFEBABE, 4'h3, 0, 32'h0,         0, 32'h13, 0, 32'h0,        1, 32'h2004, 4'h3, 32'hCAFEBABE, 1, 1};
    vecs[5]  = '{0, 32'h0,   1, 32'h2004, 32'hCAFEBABE, 4'h3, 0, 32'h0,         0, 32'h13, 0, 32'h0,        1, 32'h2004, 4'h3, 32'hCAFEBABE, 1, 1};
    vecs[6]  = '{0, 32'h0,   1, 32'h2004, 32'hCAFEBABE, 4'h3, 1, 32'hDEADBEEF,  0, 32'h13, 1, 32'hDEADBEEF, 0, 32'h0,    4'h0, 32'h0,        0, 1};
    vecs[7]  = '{0, 32'h0,   0, 32'h0,    32'h0,        4'h0, 0, 32'h0,         0, 32'h13, 0, 32'hDEADBEEF, 0, 32'h0,    4'h0, 32'h0,        0, 1};
    vecs[8]  = '{0, 32'h0,   0, 32'h0,    32'h0,        4'h0, 1, 32'h55,        0, 32'h13, 0, 32'hDEADBEEF, 0, 32'h0,    4'h0, 32'h0,        0, 1};
    vecs[9]  = '{0, 32'h0,   1, 32'h300,  32'h0,        4'h0, 0, 32'h0,         0, 32'h13, 0, 32'hDEADBEEF, 1, 32'h300,  4'h0, 32'h0,        1, 1};
    vecs[10] = '{0, 32'h0,   1, 32'h300,  32'h0,        4'h0, 1, 32'h11,        0, 32'h13, 1, 32'h11,       0, 32'h0,    4'h0, 32'h0,        0, 1};
    vecs[11] = '{0, 32'h0,   1, 32'h304,  32'h0,        4'h0, 0, 32'h0,         0, 32'h13, 0, 32'h11,       1, 32'h304,  4'h0, 32'h0,        1, 1};
    vecs[12] = '{0, 32'h0,   1, 32'h304,  32'h0,        4'h0, 1, 32'h22,        0, 32'h13, 1, 32'h22,       0, 32'h0,    4'h0, 32'h0,        0, 1};
    vecs[13] = '{0, 32'h0,   0, 32'h0,    32'h0,        4'h0, 0, 32'h0,         0, 32'h13, 0, 32'h22,       0, 32'h0,    4'h0, 32'h0,        0, 1};

    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
    check("reset f_valid",   {31'b0, f_valid},   32'h0);
    check("reset d_valid",   {31'b0, d_valid},   32'h0);
    check("reset mem_ready", {31'b0, mem_ready}, 32'h0);
    check("reset mem_addr",  mem_addr,           32'h0);
    check("reset busy",      {31'b0, busy},      32'h0);
    check("reset grant",     {31'b0, grant},     32'h0);
    check("reset timeout",   {31'b0, timeout},   32'h0);

    for (int i = 0; i < 14; i++) begin
      f_req = vecs[i].fq; f_addr = vecs[i].fa;
      d_req = vecs[i].dq; d_addr = vecs[i].da; d_wdata = vecs[i].dw; d_wstrb = vecs[i].ds;
      mem_valid = vecs[i].mv; mem_rdata = vecs[i].mr;
      step();
      check($sformatf("row%0d f_valid", i),   {31'b0, f_valid},   {31'b0, vecs[i].fv});
      check($sformatf("row%0d f_rdata", i),   f_rdata,            vecs[i].frd);
      check($sformatf("row%0d d_valid", i),   {31'b0, d_valid},   {31'b0, vecs[i].dv});
      check($sformatf("row%0d d_rdata", i),   d_rdata,            vecs[i].drd);
      check($sformatf("row%0d mem_ready", i), {31'b0, mem_ready}, {31'b0, vecs[i].mrdy});
      check($sformatf("row%0d mem_wstrb", i), {28'b0, mem_wstrb}, {28'b0, vecs[i].mws});
      check($sformatf("row%0d busy", i),      {31'b0, busy},      {31'b0, vecs[i].bsy});
      check($sformatf("row%0d grant", i),     {31'b0, grant},     {31'b0, vecs[i].gnt});
      if (vecs[i].mrdy) begin
        check($sformatf("row%0d mem_addr", i),  mem_addr,  vecs[i].maddr);
        check($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].mwd);
      end
    end

    // Contention with 1-cycle memory: streak starts at 0, so D,D,D,D,F repeats.
    f_req = 1; f_addr = 32'h400; d_req = 1; d_addr = 32'h800; d_wdata = '0; d_wstrb = '0;
    for (int g = 0; g < 10; g++) begin
      logic exp_d;
      exp_d = (g % 5) != 4;
      mem_valid = 0;
      step();
      check($sformatf("cont%0d mem_ready", g), {31'b0, mem_ready}, 32'h1);
      check($sformatf("cont%0d grant", g),     {31'b0, grant},     {31'b0, exp_d});
      check($sformatf("cont%0d mem_addr", g),  mem_addr,           exp_d ? 32'h800 : 32'h400);
      mem_valid = 1; mem_rdata = 32'h1000 + g;
      step();
      check($sformatf("cont%0d d_valid", g), {31'b0, d_valid}, {31'b0, exp_d});
      check($sformatf("cont%0d f_valid", g), {31'b0, f_valid}, {31'b0, !exp_d});
    end
    idle_inputs();
    step();

    // Reset asserted mid-transaction takes effect without waiting for a clock edge.
    d_req = 1; d_addr = 32'hA00; d_wstrb = 4'hF; d_wdata = 32'h5A5A5A5A;
    step();
    check("rst_mid pre mem_ready", {31'b0, mem_ready}, 32'h1);
    #2 reset = 1;
    #1;
    check("rst_mid mem_ready", {31'b0, mem_ready}, 32'h0);
    check("rst_mid mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    check("rst_mid busy",      {31'b0, busy},      32'h0);
    check("rst_mid grant",     {31'b0, grant},     32'h0);
    check("rst_mid d_rdata",   d_rdata,            32'h0);
    idle_inputs();
    step();
    reset = 0;
    mem_valid = 1; mem_rdata = 32'h77;
    step();
    check("rst_late d_valid", {31'b0, d_valid}, 32'h0);
    check("rst_late f_valid", {31'b0, f_valid}, 32'h0);
    check("rst_late busy",    {31'b0, busy},    32'h0);
    check("rst_late d_rdata", d_rdata,          32'h0);
    mem_valid = 0;
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    f_req = 1; f_addr = 32'hB00;
    step();
    check("to grant mem_ready", {31'b0, mem_ready}, 32'h1);
    for (int c = 1; c < 8; c++) begin
      step();
      check($sformatf("to wait%0d f_valid", c), {31'b0, f_valid}, 32'h0);
    end
    f_req = 0;
    step();
    check("to f_valid",   {31'b0, f_valid},   32'h1);
    check("to f_rdata",   f_rdata,            32'h0);
    check("to mem_ready", {31'b0, mem_ready}, 32'h0);
    check("to timeout",   {31'b0, timeout},   32'h1);
    f_req = 1; f_addr = 32'hC00;
    step();
    check("to next grant", {31'b0, mem_ready}, 32'h1);
    check("to next addr",  mem_addr,           32'hC00);
    mem_valid = 1; mem_rdata = 32'h99;
    step();
    check("to next f_rdata", f_rdata,          32'h99);
    check("to sticky",       {31'b0, timeout}, 32'h1);
    idle_inputs();
    step();
`else
    check("timeout tied low", {31'b0, timeout}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
